// File: rtl/wbh_reset_fsm.sv
// Power-up / soft-reboot sequencer feeding the wishbone-host register block.
// Optional watchdog-triggered soft reboot is built when WBH_RST_WDOG_EN is defined.
module wbh_reset_fsm #(
  parameter int unsigned INIT_WAIT_CYC  = 1024,
  parameter int unsigned FAST_WAIT_CYC  = 8,
  parameter int unsigned STRAP_CYC      = 4,
  parameter int unsigned CLK_SETTLE_CYC = 4,
  parameter int unsigned SOFT_RST_CYC   = 16,
  parameter int unsigned WDOG_CYC       = 65535
) (
  input  logic        mclk,
  input  logic        e_reset,
  input  logic        cfg_fast_sim,
  input  logic        soft_reboot_req,
  input  logic [31:0] pad_strap,
  input  logic        wdog_enb,
  input  logic        wdog_kick,
  output logic        p_reset_n,
  output logic        s_reset_n,
  output logic        clk_enb,
  output logic        soft_reboot,
  output logic        wdog_reboot,
  output logic [31:0] strap_sticky,
  output logic [2:0]  rst_state
);

  localparam int unsigned CNT_W   = 16;
  localparam int unsigned STRAP_W = 32;

  localparam logic [CNT_W-1:0] INIT_LD  = CNT_W'(INIT_WAIT_CYC - 1);
  localparam logic [CNT_W-1:0] FAST_LD  = CNT_W'(FAST_WAIT_CYC - 1);
  localparam logic [CNT_W-1:0] STRAP_LD = CNT_W'(STRAP_CYC - 1);
  localparam logic [CNT_W-1:0] CLK_LD   = CNT_W'(CLK_SETTLE_CYC - 1);
  localparam logic [CNT_W-1:0] SOFT_LD  = CNT_W'(SOFT_RST_CYC - 1);
  localparam logic [CNT_W-1:0] WDOG_LD  = CNT_W'(WDOG_CYC - 1);

  typedef enum logic [2:0] {
    ST_RESET      = 3'd0,
    ST_WAIT_INIT  = 3'd1,
    ST_STRAP_LOAD = 3'd2,
    ST_CLK_EN     = 3'd3,
    ST_RUN        = 3'd4,
    ST_SOFT_RST   = 3'd5
  } state_e;

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [STRAP_W-1:0] strap_q, strap_d;
  logic               p_rst_q, p_rst_d;
  logic               s_rst_q, s_rst_d;
  logic               clk_enb_q, clk_enb_d;
  logic               soft_q, soft_d;
  logic               wflag_q, wflag_d;
  logic               wdog_expire_c;

`ifdef WBH_RST_WDOG_EN
  logic [CNT_W-1:0] wdog_q, wdog_d;

  // Watchdog counts down only while enabled in RUN; a kick beats a same-edge expiry.
  always_comb begin
    wdog_d        = WDOG_LD;
    wdog_expire_c = 1'b0;
    if (state_q == ST_RUN && wdog_enb && !wdog_kick) begin
      if (wdog_q == '0) begin
        wdog_expire_c = 1'b1;
      end else begin
        wdog_d = wdog_q - CNT_W'(1);
      end
    end
  end

  always_ff @(posedge mclk) begin
    if (e_reset) begin
      wdog_q <= WDOG_LD;
    end else begin
      wdog_q <= wdog_d;
    end
  end
`else
  logic unused_wdog;

  assign wdog_expire_c = 1'b0;
  assign unused_wdog   = ^{wdog_enb, wdog_kick, WDOG_LD};
`endif

  // Next-state, counter and sticky-flag logic; outputs decoded from the next state.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    strap_d = strap_q;
    soft_d  = soft_q;
    wflag_d = wflag_q;

    unique case (state_q)
      ST_RESET: begin
        state_d = ST_WAIT_INIT;
        cnt_d   = cfg_fast_sim ? FAST_LD : INIT_LD;
      end
      ST_WAIT_INIT: begin
        if (cnt_q == '0) begin
          state_d = ST_STRAP_LOAD;
          cnt_d   = STRAP_LD;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      ST_STRAP_LOAD: begin
        strap_d = pad_strap;
        if (cnt_q == '0) begin
          state_d = ST_CLK_EN;
          cnt_d   = CLK_LD;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      ST_CLK_EN: begin
        if (cnt_q == '0) begin
          state_d = ST_RUN;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      ST_RUN: begin
        if (soft_reboot_req || wdog_expire_c) begin
          state_d = ST_SOFT_RST;
          cnt_d   = SOFT_LD;
          soft_d  = 1'b1;
          if (wdog_expire_c) begin
            wflag_d = 1'b1;
          end
        end
      end
      ST_SOFT_RST: begin
        if (cnt_q == '0) begin
          state_d = ST_RUN;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      default: begin
        state_d = ST_RESET;
        cnt_d   = '0;
      end
    endcase

    p_rst_d   = !(state_d inside {ST_RESET, ST_WAIT_INIT});
    clk_enb_d = state_d inside {ST_CLK_EN, ST_RUN, ST_SOFT_RST};
    s_rst_d   = (state_d == ST_RUN);
  end

  always_ff @(posedge mclk) begin
    if (e_reset) begin
      state_q   <= ST_RESET;
      cnt_q     <= '0;
      strap_q   <= '0;
      p_rst_q   <= 1'b0;
      s_rst_q   <= 1'b0;
      clk_enb_q <= 1'b0;
      soft_q    <= 1'b0;
      wflag_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      strap_q   <= strap_d;
      p_rst_q   <= p_rst_d;
      s_rst_q   <= s_rst_d;
      clk_enb_q <= clk_enb_d;
      soft_q    <= soft_d;
      wflag_q   <= wflag_d;
    end
  end

  assign p_reset_n    = p_rst_q;
  assign s_reset_n    = s_rst_q;
  assign clk_enb      = clk_enb_q;
  assign soft_reboot  = soft_q;
  assign wdog_reboot  = wflag_q;
  assign strap_sticky = strap_q;
  assign rst_state    = state_q;

endmodule

// File: tb/tb_wbh_reset_fsm.sv
// Self-checking bench for wbh_reset_fsm: expected per-edge outputs are queued
// as stimulus is applied and popped once the edge has produced DUT outputs.
module tb_wbh_reset_fsm;

  localparam int FAST_N  = 8;
  localparam int SLOW_N  = 1024;
  localparam int STRAP_N = 4;
  localparam int CLK_N   = 4;
  localparam int WDOG_N  = 100;
  localparam logic [31:0] BOOT_STRAP = 32'hA5A5_0001;

  logic        mclk = 1'b0;
  logic        e_reset;
  logic        cfg_fast_sim;
  logic        soft_reboot_req;
  logic [31:0] pad_strap;
  logic        wdog_enb;
  logic        wdog_kick;
  logic        p_reset_n;
  logic        s_reset_n;
  logic        clk_enb;
  logic        soft_reboot;
  logic        wdog_reboot;
  logic [31:0] strap_sticky;
  logic [2:0]  rst_state;

  typedef struct packed {
    logic [2:0]  st;
    logic        p;
    logic        s;
    logic        c;
    logic        sr;
    logic        wr;
    logic        chk_strap;
    logic [31:0] strap;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_errors = 0;

  always #5 mclk = ~mclk;

  wbh_reset_fsm #(.WDOG_CYC(WDOG_N)) dut (
    .mclk            (mclk),
    .e_reset         (e_reset),
    .cfg_fast_sim    (cfg_fast_sim),
    .soft_reboot_req (soft_reboot_req),
    .pad_strap       (pad_strap),
    .wdog_enb        (wdog_enb),
    .wdog_kick       (wdog_kick),
    .p_reset_n       (p_reset_n),
    .s_reset_n       (s_reset_n),
    .clk_enb         (clk_enb),
    .soft_reboot     (soft_reboot),
    .wdog_reboot     (wdog_reboot),
    .strap_sticky    (strap_sticky),
    .rst_state       (rst_state)
  );

  task automatic tick();
    @(posedge mclk);
    #1;
  endtask

  function automatic exp_t cur_obs();
    exp_t r;
    r.st        = rst_state;
    r.p         = p_reset_n;
    r.s         = s_reset_n;
    r.c         = clk_enb;
    r.sr        = soft_reboot;
    r.wr        = wdog_reboot;
    r.chk_strap = 1'b1;
    r.strap     = strap_sticky;
    return r;
  endfunction

  // Expected outputs k edges after e_reset is first sampled low (k<=0: in reset).
  // strap_sticky is left unchecked while straps are still being sampled.
  function automatic exp_t boot_exp(int k, int n);
    exp_t r = '0;
    r.chk_strap = 1'b1;
    if (k <= 0) begin
      r.st = 3'd0;
    end else if (k <= n) begin
      r.st = 3'd1;
    end else if (k <= n + STRAP_N) begin
      r.st = 3'd2; r.p = 1'b1; r.chk_strap = 1'b0;
    end else if (k <= n + STRAP_N + CLK_N) begin
      r.st = 3'd3; r.p = 1'b1; r.c = 1'b1; r.strap = BOOT_STRAP;
    end else begin
      r.st = 3'd4; r.p = 1'b1; r.c = 1'b1; r.s = 1'b1; r.strap = BOOT_STRAP;
    end
    return r;
  endfunction

  task automatic test_reset();
    e_reset = 1'b1; soft_reboot_req = 1'b1; pad_strap = 32'hFFFF_FFFF;
    for (int k = 0; k < 3; k++) begin
      exp_t e, a;
      exp_q.push_back(boot_exp(0, FAST_N));
      tick();
      e = exp_q.pop_front(); a = cur_obs();
      n_checks++;
      if (a !== e) begin
        n_errors++;
        $display("FAIL reset step=%0d got=%h want=%h", k, a, e);
      end
    end
    soft_reboot_req = 1'b0;
  endtask

  // Releases e_reset and follows the boot timeline for stop_k edges.
  task automatic run_boot(string name, logic fast, int stop_k);
    int n = fast ? FAST_N : SLOW_N;
    cfg_fast_sim = fast; pad_strap = BOOT_STRAP; e_reset = 1'b0;
    for (int k = 1; k <= stop_k; k++) begin
      exp_t e, a;
      if (k == 2) cfg_fast_sim = ~fast;
      if (k == n + STRAP_N + 2) pad_strap = 32'h0;
      exp_q.push_back(boot_exp(k, n));
      tick();
      e = exp_q.pop_front(); a = cur_obs();
      if (!e.chk_strap) a.strap = e.strap;
      a.chk_strap = e.chk_strap;
      n_checks++;
      if (a !== e) begin
        n_errors++;
        $display("FAIL %s edge=%0d got=%h want=%h", name, k, a, e);
      end
    end
    cfg_fast_sim = fast;
  endtask

  task automatic test_fast_boot();
    run_boot("fast_boot", 1'b1, FAST_N + STRAP_N + CLK_N + 4);
  endtask

  task automatic test_soft_reboot();
    pad_strap = 32'h0000_1234;
    for (int m = 0; m < 36; m++) begin
      exp_t e, a;
      logic in_soft;
      soft_reboot_req = (m == 0) || (m == 7) || (m == 17);
      in_soft = (m <= 15) || (m >= 17 && m <= 32);
      e = '0;
      e.st = in_soft ? 3'd5 : 3'd4;
      e.p = 1'b1; e.c = 1'b1; e.s = !in_soft; e.sr = 1'b1;
      e.chk_strap = 1'b1; e.strap = BOOT_STRAP;
      exp_q.push_back(e);
      tick();
      e = exp_q.pop_front(); a = cur_obs();
      n_checks++;
      if (a !== e) begin
        n_errors++;
        $display("FAIL soft_reboot step=%0d got=%h want=%h", m, a, e);
      end
    end
    soft_reboot_req = 1'b0;
  endtask

  task automatic test_reset_mid();
    exp_t e, a;
    e_reset = 1'b1; soft_reboot_req = 1'b1;
    exp_q.push_back(boot_exp(0, FAST_N));
    tick();
    soft_reboot_req = 1'b0;
    e = exp_q.pop_front(); a = cur_obs();
    n_checks++;
    if (a !== e) begin
      n_errors++;
      $display("FAIL reset_vs_req got=%h want=%h", a, e);
    end
    run_boot("to_strap", 1'b1, FAST_N + 2);
    e_reset = 1'b1;
    exp_q.push_back(boot_exp(0, FAST_N));
    tick();
    e = exp_q.pop_front(); a = cur_obs();
    n_checks++;
    if (a !== e) begin
      n_errors++;
      $display("FAIL mid_abort got=%h want=%h", a, e);
    end
    run_boot("restart", 1'b1, FAST_N + STRAP_N + CLK_N + 4);
  endtask

  // Kick lands on the expiry edge at m=99, then every 50; last kick at 249.
  task automatic test_watchdog();
`ifdef WBH_RST_WDOG_EN
    int exp_m = 249 + WDOG_N;
`else
    int exp_m = -1;
`endif
    wdog_enb = 1'b1;
    for (int m = 0; m <= 365; m++) begin
      exp_t e, a;
      logic fired, in_soft;
      wdog_kick = (m == 99) || (m == 149) || (m == 199) || (m == 249);
      fired   = (exp_m >= 0) && (m >= exp_m);
      in_soft = fired && (m <= exp_m + 15);
      e = '0;
      e.st = in_soft ? 3'd5 : 3'd4;
      e.p = 1'b1; e.c = 1'b1; e.s = !in_soft; e.sr = fired; e.wr = fired;
      e.chk_strap = 1'b1; e.strap = BOOT_STRAP;
      exp_q.push_back(e);
      tick();
      e = exp_q.pop_front(); a = cur_obs();
      n_checks++;
      if (a !== e) begin
        n_errors++;
        $display("FAIL watchdog step=%0d got=%h want=%h", m, a, e);
      end
    end
    wdog_enb = 1'b0; wdog_kick = 1'b0;
  endtask

  task automatic test_slow_boot();
    exp_t e, a;
    e_reset = 1'b1;
    exp_q.push_back(boot_exp(0, SLOW_N));
    tick();
    e = exp_q.pop_front(); a = cur_obs();
    n_checks++;
    if (a !== e) begin
      n_errors++;
      $display("FAIL slow_reset got=%h want=%h", a, e);
    end
    run_boot("slow_boot", 1'b0, SLOW_N + STRAP_N + CLK_N + 3);
  endtask

  initial begin
    e_reset = 1'b1; cfg_fast_sim = 1'b1; soft_reboot_req = 1'b0;
    pad_strap = 32'h0; wdog_enb = 1'b0; wdog_kick = 1'b0;
    test_reset();
    test_fast_boot();
    test_soft_reboot();
    test_reset_mid();
    test_watchdog();
    test_slow_boot();
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
